// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Iterative multiply/divide sequencer for MIPS MULT/MULTU/DIV/DIVU with the
//   architectural HI/LO registers. One shift-add (multiply) or restoring
//   shift-subtract (divide) step is done per clock. A full operation takes
//   DATA_WIDTH+1 edges after the accept edge. The EX stage stalls while
//   busy_87 is high and reads HI/LO directly for MFHI/MFLO.
//
// Ports
//   clk_87      in   clock, all state updates on the rising edge
//   rst_87      in   synchronous active-high reset, overrides everything
//   start_87    in   operation request (see handshake note below)
//   op_87       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   arg_a_87    in   multiplicand / dividend
//   arg_b_87    in   multiplier / divisor
//   flush_87    in   abort the operation in flight, HI/LO untouched
//   hi_we_87    in   MTHI strobe, honoured only while not busy
//   lo_we_87    in   MTLO strobe, honoured only while not busy
//   wdata_87    in   MTHI/MTLO data
//   busy_87     out  operation in flight (CALC or FIX)
//   done_87     out  one-cycle pulse, HI/LO hold the new result
//   dbz_87      out  divide-by-zero flag, only meaningful with done_87
//   hi_87       out  HI register (product upper half / remainder)
//   lo_87       out  LO register (product lower half / quotient)
//
// Handshake: start_87 acts as "valid" and !busy_87 as "ready". A request is
// accepted on a rising edge where start_87=1 and busy_87=0. op_87/arg_a_87/arg_b_87
// are sampled on that edge only. Requests made while busy are dropped, not
// queued. A new request may be accepted in the same cycle done_87 is high.
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_87,
  input  logic                  rst_87,
  input  logic                  start_87,
  input  logic [1:0]            op_87,
  input  logic [DATA_WIDTH-1:0] arg_a_87,
  input  logic [DATA_WIDTH-1:0] arg_b_87,
  input  logic                  flush_87,
  input  logic                  hi_we_87,
  input  logic                  lo_we_87,
  input  logic [DATA_WIDTH-1:0] wdata_87,
  output logic                  busy_87,
  output logic                  done_87,
  output logic                  dbz_87,
  output logic [DATA_WIDTH-1:0] hi_87,
  output logic [DATA_WIDTH-1:0] lo_87
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DW - 1);
  localparam logic [DW-1:0]   ONE_DW   = DW'(1);
  localparam logic [2*DW-1:0] ONE_2DW  = (2*DW)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The FSM state is kept in one named register so that checkers can bind to it.
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;     // latched op_87[1]
  logic            neg_q;      // negate product/quotient at FIX
  logic            neg_r;      // negate remainder at FIX (sign of dividend)
  logic            div_zero;   // DIV/DIVU with zero divisor
  logic [DW-1:0]   a_orig;     // raw dividend, returned in HI on divide by zero
  logic [DW-1:0]   step_op;    // |a| added per step (mult) or |b| subtracted (div)
  // Accumulator layout:
  //   mult: [2DW:DW] running partial sum with carry, [DW-1:0] remaining multiplier bits
  //   div : [2DW:DW] partial remainder with a guard bit, [DW-1:0] dividend/quotient bits
  logic [2*DW:0]   acc;

  // ---------------------------------------------------------------------
  // Operand conditioning at accept
  // ---------------------------------------------------------------------
  logic            acc_sgn;
  logic            sign_a;
  logic            sign_b;
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  logic            can_accept;

  always_comb begin
    acc_sgn    = ~op_87[0];
    sign_a     = acc_sgn & arg_a_87[DW-1];
    sign_b     = acc_sgn & arg_b_87[DW-1];
    mag_a      = sign_a ? (~arg_a_87 + ONE_DW) : arg_a_87;
    mag_b      = sign_b ? (~arg_b_87 + ONE_DW) : arg_b_87;
    can_accept = (state == S_IDLE) || (state == S_DONE);
  end

  // ---------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------
  logic [DW:0]     mul_sum;
  logic [2*DW:0]   mul_next;
  logic [2*DW:0]   div_shift;
  logic [DW:0]     div_trial;
  logic            div_ge;
  logic [2*DW:0]   div_next;
  logic [2*DW:0]   acc_next;

  always_comb begin
    // Multiply: add |a| when the current multiplier LSB is set, then shift right.
    // acc[2DW] is always 0 before the add, so the DW+1 bit sum cannot overflow.
    mul_sum   = acc[2*DW:DW] + {1'b0, (acc[0] ? step_op : {DW{1'b0}})};
    mul_next  = {1'b0, mul_sum, acc[DW-1:1]};

    // Restoring divide: shift left, trial-subtract |b| from the partial remainder.
    // The shifted remainder can reach 2|b|-1, hence the extra guard bit.
    div_shift = {acc[2*DW-1:0], 1'b0};
    div_ge    = (div_shift[2*DW:DW] >= {1'b0, step_op});
    div_trial = div_shift[2*DW:DW] - {1'b0, step_op};
    div_next  = div_ge ? {div_trial, div_shift[DW-1:1], 1'b1} : div_shift;

    acc_next  = is_div ? div_next : mul_next;
  end

  // ---------------------------------------------------------------------
  // Sign correction / result selection for the FIX state
  // ---------------------------------------------------------------------
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quot_fix;
  logic [DW-1:0]   rem_fix;
  logic [DW-1:0]   fix_hi;
  logic [DW-1:0]   fix_lo;

  always_comb begin
    prod_fix = neg_q ? (~acc[2*DW-1:0] + ONE_2DW) : acc[2*DW-1:0];
    quot_fix = neg_q ? (~acc[DW-1:0] + ONE_DW) : acc[DW-1:0];
    rem_fix  = neg_r ? (~acc[2*DW-1:DW] + ONE_DW) : acc[2*DW-1:DW];
    fix_hi   = prod_fix[2*DW-1:DW];
    fix_lo   = prod_fix[DW-1:0];
    if (div_zero) begin
      // Divide by zero: the iteration result is meaningless and the sign fix is skipped.
      fix_hi = a_orig;
      fix_lo = {DW{1'b1}};
    end else if (is_div) begin
      fix_hi = rem_fix;
      fix_lo = quot_fix;
    end
  end

  // ---------------------------------------------------------------------
  // FSM and architectural registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= '0;
      step_op  <= '0;
      acc      <= '0;
      busy_87  <= 1'b0;
      done_87  <= 1'b0;
      dbz_87   <= 1'b0;
      hi_87    <= '0;
      lo_87    <= '0;
    end else begin
      done_87 <= 1'b0;
      dbz_87  <= 1'b0;

      // MTHI/MTLO only while idle. If a start is accepted on the same edge the
      // write still lands; the completion write replaces it later.
      if (can_accept && hi_we_87) hi_87 <= wdata_87;
      if (can_accept && lo_we_87) lo_87 <= wdata_87;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_87) begin
            state    <= S_CALC;
            busy_87  <= 1'b1;
            cnt      <= '0;
            is_div   <= op_87[1];
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= op_87[1] && (arg_b_87 == '0);
            a_orig   <= arg_a_87;
            step_op  <= op_87[1] ? mag_b : mag_a;
            acc      <= op_87[1] ? {{(DW+1){1'b0}}, mag_a} : {{(DW+1){1'b0}}, mag_b};
          end else begin
            state <= S_IDLE;
          end
        end

        S_CALC: begin
          if (flush_87) begin
            state   <= S_IDLE;
            busy_87 <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) state <= S_FIX;
          end
        end

        S_FIX: begin
          if (flush_87) begin
            state   <= S_IDLE;
            busy_87 <= 1'b0;
          end else begin
            state   <= S_DONE;
            busy_87 <= 1'b0;
            done_87 <= 1'b1;
            dbz_87  <= div_zero;
            hi_87   <= fix_hi;
            lo_87   <= fix_lo;
          end
        end

        default: begin
          state   <= S_IDLE;
          busy_87 <= 1'b0;
        end
      endcase
    end
  end

endmodule
